main_memory_responder: RTL and testbench

- Main-memory side of the cache/memory refill interface. Serves block-granular read (refill) and write (write-back eviction) bursts issued by the write-back cache controller.
- Word-serial burst of 4 x 32-bit beats per 16-byte block, after a programmable access latency.
- Owns the backing word array `mem`. Bench code probes it hierarchically as `mem.mem[i]`.

---
 rtl/main_memory_responder.sv | 168 ++++++++++++++++
 tb/tb_main_memory_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Main-memory responder: block-granular read/write bursts (4 x 32-bit beats) after a fixed latency.
// Optional MEM_CRITICAL_WORD_FIRST_EN: read bursts start at memAddr[3:2] and wrap.
module main_memory_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memReq,
    input  logic                  memIsRead,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [31:0]           memWriteData,
    output logic [31:0]           memReadData,
    output logic                  memReadValid,
    output logic                  memWriteReady,
    output logic                  memBusy,
    output logic                  memDone
);
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned BASE_W = ADDR_WIDTH - 4;
    localparam int unsigned DEPTH  = 1 << IDX_W;
    localparam int unsigned LAT_W  = $clog2(LATENCY + 2);
    localparam logic [1:0]  LAST_BEAT = 2'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    // Contents survive reset; only the power-up image is fixed.
    logic [31:0] mem [DEPTH] = '{0: 32'h0000_3cc3, 128: 32'h0000_0ccc, 192: 32'h0000_00c3,
                                 default: 32'h0};

    state_t              r_state, w_state_d;
    logic [LAT_W-1:0]    r_lat, w_lat_d;
    logic [1:0]          r_beat, w_beat_d;
    logic                r_is_read;
    logic [BASE_W-1:0]   r_base;
    logic [1:0]          r_off;
    logic [31:0]         r_rdata, w_rdata_d;
    logic                r_rvalid, w_rvalid_d;
    logic                r_wready, w_wready_d;
    logic                r_busy, w_busy_d;
    logic                r_done, w_done_d;

    logic                w_accept;
    logic                w_issue;
    logic [1:0]          w_issue_beat;
    logic                w_is_read;
    logic [BASE_W-1:0]   w_base;
    logic [1:0]          w_off;
    logic [1:0]          w_rd_off;
    logic                w_mem_we;

    always_comb begin
        // With LATENCY=0 the first beat is issued on the accept edge, before the latch.
        w_is_read    = (r_state == IDLE) ? memIsRead : r_is_read;
        w_base       = (r_state == IDLE) ? memAddr[ADDR_WIDTH-1:4] : r_base;
        w_off        = (r_state == IDLE) ? memAddr[3:2] : r_off;
        w_state_d    = r_state;
        w_lat_d      = r_lat;
        w_beat_d     = r_beat;
        w_rdata_d    = 32'h0;
        w_rvalid_d   = 1'b0;
        w_wready_d   = 1'b0;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_issue_beat = 2'd0;
        w_mem_we     = 1'b0;
        w_rd_off     = 2'd0;

        unique case (r_state)
            IDLE: begin
                if (memReq) begin
                    w_accept = 1'b1;
                    w_busy_d = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_d = BURST;
                        w_issue   = 1'b1;
                    end else begin
                        w_state_d = WAIT;
                        w_lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_lat == '0) begin
                    w_state_d = BURST;
                    w_issue   = 1'b1;
                end else begin
                    w_lat_d = r_lat - LAT_W'(1);
                end
            end
            BURST: begin
                w_mem_we = !r_is_read;
                if (r_beat == LAST_BEAT) begin
                    w_state_d = IDLE;
                    w_busy_d  = 1'b0;
                end else begin
                    w_issue      = 1'b1;
                    w_issue_beat = r_beat + 2'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase

`ifdef MEM_CRITICAL_WORD_FIRST_EN
        w_rd_off = w_off + w_issue_beat;
`else
        w_rd_off = w_issue_beat;
`endif

        if (w_issue) begin
            w_beat_d = w_issue_beat;
            w_done_d = (w_issue_beat == LAST_BEAT);
            if (w_is_read) begin
                w_rvalid_d = 1'b1;
                w_rdata_d  = mem[{w_base, w_rd_off}];
            end else begin
                w_wready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lat     <= '0;
            r_beat    <= 2'd0;
            r_is_read <= 1'b0;
            r_base    <= '0;
            r_off     <= 2'd0;
            r_rdata   <= 32'h0;
            r_rvalid  <= 1'b0;
            r_wready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_lat     <= w_lat_d;
            r_beat    <= w_beat_d;
            r_rdata   <= w_rdata_d;
            r_rvalid  <= w_rvalid_d;
            r_wready  <= w_wready_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            if (w_accept) begin
                r_is_read <= memIsRead;
                r_base    <= memAddr[ADDR_WIDTH-1:4];
                r_off     <= memAddr[3:2];
            end
        end
    end

    // Write beats always run offsets 0..3; r_beat is the beat being closed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[{r_base, r_beat}] <= memWriteData;
        end
    end

    assign memReadData   = r_rdata;
    assign memReadValid  = r_rvalid;
    assign memWriteReady = r_wready;
    assign memBusy       = r_busy;
    assign memDone       = r_done;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios plus random bursts
// checked against a word-array reference model.
module tb_main_memory_responder;
    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memReq = 1'b0;
    logic        memIsRead = 1'b0;
    logic [9:0]  memAddr = 10'h0;
    logic [31:0] memWriteData = 32'h0;
    logic [31:0] memReadData;
    logic        memReadValid;
    logic        memWriteReady;
    logic        memBusy;
    logic        memDone;

    main_memory_responder #(
        .LATENCY    (L),
        .ADDR_WIDTH (10),
        .BLOCK_WORDS(4)
    ) mem (
        .clk          (clk),
        .rst_n        (rst_n),
        .memReq       (memReq),
        .memIsRead    (memIsRead),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memReadValid (memReadValid),
        .memWriteReady(memWriteReady),
        .memBusy      (memBusy),
        .memDone      (memDone)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [256];
    logic [31:0] wd [4];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [9:0] addr, input bit is_read, input int k);
        int off;
        off = 0;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
        if (is_read) off = int'(addr[3:2]);
`endif
        return int'(addr[9:4]) * 4 + ((off + k) % 4);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(memBusy), 32'h0);
        check_eq({tag, "_rvalid"}, 32'(memReadValid), 32'h0);
        check_eq({tag, "_wready"}, 32'(memWriteReady), 32'h0);
        check_eq({tag, "_done"}, 32'(memDone), 32'h0);
        check_eq({tag, "_rdata"}, memReadData, 32'h0);
    endtask

    task automatic check_block(input int blk, input string tag);
        for (int i = 0; i < 4; i++) check_eq($sformatf("%s_mem%0d", tag, blk * 4 + i),
                                             mem.mem[blk * 4 + i], model[blk * 4 + i]);
    endtask

    // Drives one transaction; called at a negedge, returns at the negedge where memBusy
    // has just fallen. glitch: cycle to pulse a stray memReq; abort: cycle to assert reset.
    task automatic txn(input bit is_read, input logic [9:0] addr, input int glitch,
                       input int abort, input string tag);
        int          waited;
        int          k;
        bit          in_burst;
        logic [31:0] exp_rd [4];
        waited = 0;
        while (memBusy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (memBusy) begin
            check_eq({tag, "_idle_timeout"}, 32'(memBusy), 32'h0);
            return;
        end
        for (int i = 0; i < 4; i++) exp_rd[i] = model[word_of(addr, is_read, i)];
        memReq    = 1'b1;
        memIsRead = is_read;
        memAddr   = addr;
        @(posedge clk);
        @(negedge clk);
        memReq = 1'b0;
        for (int j = 0; j <= int'(L) + 4; j++) begin
            if (j == abort) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs({tag, "_abort"});
                for (int b = 0; b < j - int'(L); b++) model[word_of(addr, 1'b0, b)] = wd[b];
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            k        = j - int'(L);
            in_burst = (j >= int'(L)) && (j < int'(L) + 4);
            check_eq($sformatf("%s_busy_c%0d", tag, j), 32'(memBusy), 32'(j < int'(L) + 4));
            check_eq($sformatf("%s_rvalid_c%0d", tag, j), 32'(memReadValid),
                     32'(is_read && in_burst));
            check_eq($sformatf("%s_wready_c%0d", tag, j), 32'(memWriteReady),
                     32'(!is_read && in_burst));
            check_eq($sformatf("%s_done_c%0d", tag, j), 32'(memDone), 32'(j == int'(L) + 3));
            check_eq($sformatf("%s_rdata_c%0d", tag, j), memReadData,
                     (is_read && in_burst) ? exp_rd[k] : 32'h0);
            if (!is_read && in_burst) memWriteData = wd[k];
            if (j == glitch) begin
                memReq    = 1'b1;
                memIsRead = 1'b0;
            end else begin
                memReq = 1'b0;
            end
            if (j < int'(L) + 4) @(negedge clk);
        end
        if (!is_read) for (int b = 0; b < 4; b++) model[word_of(addr, 1'b0, b)] = wd[b];
    endtask

    initial begin
        bit         rd;
        logic [9:0] a;
        int         g;

        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        model[0]   = 32'h0000_3cc3;
        model[128] = 32'h0000_0ccc;
        model[192] = 32'h0000_00c3;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 10'h000, -1, -1, "rd0");
        wd[0] = 32'hff; wd[1] = 32'h11; wd[2] = 32'h22; wd[3] = 32'h33;
        txn(1'b0, 10'h000, -1, -1, "wr0");
        check_eq("mem0_after_wr", mem.mem[0], 32'h0000_00ff);
        txn(1'b1, 10'h000, -1, -1, "rd0_after_wr");

        txn(1'b1, 10'h200, -1, -1, "rd200");
        txn(1'b1, 10'h300, -1, -1, "rd300");

        txn(1'b1, 10'h200, 1, -1, "glitch");
        for (int i = 0; i < 8; i++) begin
            check_eq("no_extra_burst", 32'(memBusy), 32'h0);
            @(negedge clk);
        end
        check_block(0, "glitch_blk0");

        for (int i = 0; i < 4; i++) wd[i] = 32'h5000 + i;
        txn(1'b0, 10'h040, -1, -1, "pre_abort");
        for (int i = 0; i < 4; i++) wd[i] = $urandom();
        txn(1'b0, 10'h040, -1, int'(L) + 2, "abort");
        check_block(4, "abort_blk4");
        check_eq("abort_mem18_old", mem.mem[18], 32'h5002);

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        txn(1'b0, 10'h000, -1, -1, "wr_abcd");
        txn(1'b1, 10'h008, -1, -1, "rd008");

        for (int n = 0; n < 24; n++) begin
            rd = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 1023));
            g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L + 2)) : -1;
            for (int i = 0; i < 4; i++) wd[i] = $urandom();
            txn(rd, a, g, -1, $sformatf("rand%0d", n));
            if (!rd) check_block(int'(a[9:4]), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
